ne_coeff_arbiter: RTL and testbench
===================================

NE_COEFF_ARBITER -- requirements
Module: ne_coeff_arbiter

Interface
REQ-001 SHALL have parameters: NREQ=4 (requester ports, 2..8); ADDR_W=9 (line address); WDATA_W=32 (write word); LINE_W=512 (read line); RD_LAT=1 (SRAM read latency, 1..4); STARVE_MAX=8 (write wait limit, only used under NE_ARB_RD_PRIO_EN).
REQ-002 SHALL have ports, in this order:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-port access request, held until granted.
- we  in  NREQ  per-port write (1) / read (0) qualifier, valid with req.
- addr  in  NREQ*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W].
- wdata  in  NREQ*WDATA_W  per-port write word.
- gnt  out  NREQ  one-hot grant pulse: port's request accepted.
- rvalid  out  NREQ  one-hot read-data-valid pulse.
- rdata  out  LINE_W  read line, broadcast to all ports.
- coeff_buf_dout  in  LINE_W  SRAM read data.
- coeff_buf_addr  out  ADDR_W  SRAM address.
- coeff_buf_din  out  WDATA_W  SRAM write data.
- coeff_buf_en  out  1  SRAM enable.
- coeff_buf_we  out  1  SRAM write enable.

Function
REQ-003 SHALL sample req/we/addr/wdata each cycle t, pick at most one eligible port, and in cycle t+1 drive registered coeff_buf_en=1, coeff_buf_we/addr/din from that port, and gnt[i]=1 for exactly that cycle.
REQ-004 A port with gnt[i]=1 in the current cycle SHALL be ineligible in that cycle (its held request is already accepted); per-port peak rate is 1 access per 2 cycles, aggregate peak 1 per cycle.
REQ-005 Arbitration SHALL be round-robin: search starts at rr_ptr, ascending modulo NREQ; after granting port k, rr_ptr <= (k+1) mod NREQ; rr_ptr unchanged on idle cycles.
REQ-006 With no eligible request, coeff_buf_en=0, coeff_buf_we=0, gnt=0; coeff_buf_addr/din hold their last value.
REQ-007 For a read issued with coeff_buf_en=1 in cycle u, rvalid[i]=1 and rdata=coeff_buf_dout in cycle u+RD_LAT; a RD_LAT-deep tag pipeline (valid + port index) SHALL track all outstanding reads, so back-to-back reads from different ports return in issue order without loss.
REQ-008 rdata SHALL be coeff_buf_dout passed combinationally; rdata is meaningful only when any rvalid bit is 1.
REQ-009 Writes SHALL produce gnt only; no rvalid.
REQ-010 gnt and rvalid SHALL each be one-hot or zero in every cycle; gnt and rvalid for different ports may coincide.
REQ-011 req deasserted before grant SHALL withdraw the request without error; change of we/addr/wdata while req=1 and ungranted SHALL be accepted (value sampled at selection is used).

Reset
REQ-012 On rst=0 (any time, asynchronously): gnt=0, rvalid=0, coeff_buf_en=0, coeff_buf_we=0, coeff_buf_addr=0, coeff_buf_din=0, rr_ptr=0, read-tag pipeline cleared, starvation counters 0.
REQ-013 Reads in flight at reset SHALL be discarded (no rvalid after reset release); first grant possible in the cycle after the first rising edge with rst=1.

Configuration
REQ-014 Macro NE_ARB_RD_PRIO_EN SHALL select policy. Defined: eligible reads take precedence over eligible writes (round-robin within each class, shared rr_ptr); a wait counter counts cycles in which a write request is pending but ungranted, and when it reaches STARVE_MAX the oldest-by-rr_ptr write is granted ahead of reads, counter cleared on any write grant. Undefined: pure round-robin per REQ-005, no counter logic synthesised.

Verification
REQ-015 Reset then single read port 2 addr 0x1A5, RD_LAT=1 -> cycle+1 coeff_buf_en=1,we=0,addr=0x1A5,gnt=0100; cycle+2 rvalid=0100, rdata=coeff_buf_dout.
REQ-016 All 4 ports hold write requests continuously, rr_ptr=0 -> grant order 0,1,2,3,0,... one per cycle, each port granted every 4th cycle.
REQ-017 RD_LAT=3, reads from ports 0,1,3 in consecutive cycles -> rvalid 0001,0010,1000 in consecutive cycles, 3 cycles after each coeff_buf_en.
REQ-018 rst asserted one cycle after read issue with RD_LAT=2 -> all outputs 0 immediately, no rvalid after release.
REQ-019 NE_ARB_RD_PRIO_EN, STARVE_MAX=8: port 0 write held, ports 1-3 reading continuously -> port 0 granted no later than the 9th arbitration cycle; without macro -> port 0 granted within 4 cycles.

Source files
------------

// File: rtl/ne_coeff_arbiter.sv
// ne_coeff_arbiter: round-robin arbiter sharing one coefficient SRAM port among NREQ requesters.
// Optional macro NE_ARB_RD_PRIO_EN: reads beat writes, with a STARVE_MAX write-wait guard.
module ne_coeff_arbiter #(
  parameter int NREQ       = 4,
  parameter int ADDR_W     = 9,
  parameter int WDATA_W    = 32,
  parameter int LINE_W     = 512,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         we,
  input  logic [NREQ*ADDR_W-1:0]  addr,
  input  logic [NREQ*WDATA_W-1:0] wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         rvalid,
  output logic [LINE_W-1:0]       rdata,
  input  logic [LINE_W-1:0]       coeff_buf_dout,
  output logic [ADDR_W-1:0]       coeff_buf_addr,
  output logic [WDATA_W-1:0]      coeff_buf_din,
  output logic                    coeff_buf_en,
  output logic                    coeff_buf_we
);

  localparam int IDX_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || RD_LAT < 1 || RD_LAT > 4 || STARVE_MAX < 1) begin : g_param_check
    $error("ne_coeff_arbiter: parameter out of range");
  end

  // Handshake: a port holds req (with we/addr/wdata) until it sees gnt. In the
  // gnt cycle the port is ineligible, so it may already present its next access.
  logic [NREQ-1:0]    r_gnt;
  logic               r_en;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [WDATA_W-1:0] r_din;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic               r_tag_v  [RD_LAT];
  logic [IDX_W-1:0]   r_tag_id [RD_LAT];

  logic [NREQ-1:0]    w_elig;
  logic [IDX_W:0]     w_pick;
  logic               w_pick_vld;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_sel_we;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [WDATA_W-1:0] w_sel_din;

  // Returns {found, index}; walks downward so the closest-to-ptr hit wins.
  function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0] mask,
                                             input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0]   res;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NREQ)) sum = sum - (IDX_W+1)'(NREQ);
      idx = sum[IDX_W-1:0];
      if (mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_elig = req & ~r_gnt;

`ifdef NE_ARB_RD_PRIO_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic [NREQ-1:0]  w_rd_mask;
  logic [NREQ-1:0]  w_wr_mask;
  logic [IDX_W:0]   w_rd_pick;
  logic [IDX_W:0]   w_wr_pick;
  logic             w_starved;

  assign w_rd_mask = w_elig & ~we;
  assign w_wr_mask = w_elig & we;
  assign w_rd_pick = rr_pick(w_rd_mask, r_rr_ptr);
  assign w_wr_pick = rr_pick(w_wr_mask, r_rr_ptr);
  assign w_starved = (r_wait_cnt == CNT_W'(STARVE_MAX));

  always_comb begin
    w_pick = w_wr_pick;
    if (!(w_starved && w_wr_pick[IDX_W]) && w_rd_pick[IDX_W]) w_pick = w_rd_pick;
  end

  // Saturating count of cycles a write was eligible but lost to a read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= '0;
    end else if (w_pick_vld && w_sel_we) begin
      r_wait_cnt <= '0;
    end else if (|w_wr_mask && !w_starved) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end
`else
  assign w_pick = rr_pick(w_elig, r_rr_ptr);
`endif

  assign w_pick_vld = w_pick[IDX_W];
  assign w_pick_idx = w_pick[IDX_W-1:0];

  always_comb begin
    w_sel_we   = 1'b0;
    w_sel_addr = '0;
    w_sel_din  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick_idx == IDX_W'(i)) begin
        w_sel_we   = we[i];
        w_sel_addr = addr[i*ADDR_W +: ADDR_W];
        w_sel_din  = wdata[i*WDATA_W +: WDATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt     <= '0;
      r_en      <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_din     <= '0;
      r_rr_ptr  <= '0;
      r_gnt_idx <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        r_tag_v[k]  <= 1'b0;
        r_tag_id[k] <= '0;
      end
    end else begin
      r_en  <= w_pick_vld;
      r_we  <= w_pick_vld & w_sel_we;
      r_gnt <= w_pick_vld ? (NREQ'(1) << w_pick_idx) : '0;
      if (w_pick_vld) begin
        r_addr    <= w_sel_addr;
        r_din     <= w_sel_din;
        r_gnt_idx <= w_pick_idx;
        r_rr_ptr  <= (w_pick_idx == IDX_W'(NREQ - 1)) ? '0 : w_pick_idx + IDX_W'(1);
      end
      // Stage 0 tags the read on the SRAM port this cycle; the last stage lines up with dout.
      r_tag_v[0]  <= r_en & ~r_we;
      r_tag_id[0] <= r_gnt_idx;
      for (int k = 1; k < RD_LAT; k++) begin
        r_tag_v[k]  <= r_tag_v[k-1];
        r_tag_id[k] <= r_tag_id[k-1];
      end
    end
  end

  always_comb begin
    rvalid = '0;
    if (r_tag_v[RD_LAT-1]) rvalid = NREQ'(1) << r_tag_id[RD_LAT-1];
  end

  assign gnt            = r_gnt;
  assign rdata          = coeff_buf_dout;
  assign coeff_buf_en   = r_en;
  assign coeff_buf_we   = r_we;
  assign coeff_buf_addr = r_addr;
  assign coeff_buf_din  = r_din;

endmodule

// File: tb/tb_ne_coeff_arbiter.sv
// Self-checking bench for ne_coeff_arbiter: cycle model feeding expected-output queues,
// directed scenarios (single read, read ordering, reset mid-flight, write round-robin, starvation) and random traffic.
module tb_ne_coeff_arbiter;

  localparam int NREQ       = 4;
  localparam int ADDR_W     = 9;
  localparam int WDATA_W    = 32;
  localparam int LINE_W     = 512;
  localparam int RD_LAT     = 3;
  localparam int STARVE_MAX = 8;
  localparam int EXP_W      = NREQ + 2 + ADDR_W + WDATA_W;

  localparam int M_DIRECT = 0;
  localparam int M_RANDOM = 1;
  localparam int M_WR_ALL = 2;
  localparam int M_STARVE = 3;

`ifdef NE_ARB_RD_PRIO_EN
  localparam int STARVE_BOUND = STARVE_MAX + 1;
`else
  localparam int STARVE_BOUND = NREQ;
`endif

  typedef struct packed {
    logic [NREQ-1:0]    gnt;
    logic               en;
    logic               we;
    logic [ADDR_W-1:0]  addr;
    logic [WDATA_W-1:0] din;
  } exp_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]         req;
  logic [NREQ-1:0]         we;
  logic [NREQ*ADDR_W-1:0]  addr;
  logic [NREQ*WDATA_W-1:0] wdata;
  logic [NREQ-1:0]         gnt;
  logic [NREQ-1:0]         rvalid;
  logic [LINE_W-1:0]       rdata;
  logic [LINE_W-1:0]       coeff_buf_dout;
  logic [ADDR_W-1:0]       coeff_buf_addr;
  logic [WDATA_W-1:0]      coeff_buf_din;
  logic                    coeff_buf_en;
  logic                    coeff_buf_we;

  logic [NREQ-1:0]    t_req;
  logic [NREQ-1:0]    t_we;
  logic [ADDR_W-1:0]  t_addr  [NREQ];
  logic [WDATA_W-1:0] t_wdata [NREQ];
  logic [LINE_W-1:0]  t_dout;

  always_comb begin
    req   = t_req;
    we    = t_we;
    addr  = '0;
    wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      addr[i*ADDR_W +: ADDR_W]    = t_addr[i];
      wdata[i*WDATA_W +: WDATA_W] = t_wdata[i];
    end
  end
  assign coeff_buf_dout = t_dout;

  ne_coeff_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .WDATA_W(WDATA_W), .LINE_W(LINE_W),
    .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .coeff_buf_dout(coeff_buf_dout),
    .coeff_buf_addr(coeff_buf_addr), .coeff_buf_din(coeff_buf_din),
    .coeff_buf_en(coeff_buf_en), .coeff_buf_we(coeff_buf_we)
  );

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  logic [39:0]      rd_q[$];
  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int mode     = M_DIRECT;
  logic st_done = 1'b0;

  logic [NREQ-1:0]    m_gnt;
  logic               m_en;
  logic               m_we;
  logic [ADDR_W-1:0]  m_addr;
  logic [WDATA_W-1:0] m_din;
  int                 m_rr;
  int                 m_cnt;

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] got,
                          input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] mask);
    int idx;
    for (int j = 0; j < NREQ; j++) begin
      idx = (m_rr + j) % NREQ;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  // Predicts the outputs of the next cycle from the inputs now being driven.
  task automatic model_step();
    logic [NREQ-1:0] el;
    logic [NREQ-1:0] rd;
    logic [NREQ-1:0] wr;
    int   p;
    exp_t ev;
    el = t_req & ~m_gnt;
    rd = el & ~t_we;
    wr = el & t_we;
`ifdef NE_ARB_RD_PRIO_EN
    if (m_cnt >= STARVE_MAX && wr != '0) p = model_pick(wr);
    else if (rd != '0)                   p = model_pick(rd);
    else                                 p = model_pick(wr);
    if (p >= 0 && t_we[p])                      m_cnt = 0;
    else if (wr != '0 && m_cnt < STARVE_MAX)    m_cnt = m_cnt + 1;
`else
    p = model_pick(el);
`endif
    if (p >= 0) begin
      m_gnt    = '0;
      m_gnt[p] = 1'b1;
      m_en     = 1'b1;
      m_we     = t_we[p];
      m_addr   = t_addr[p];
      m_din    = t_wdata[p];
      m_rr     = (p + 1) % NREQ;
      if (!t_we[p]) rd_q.push_back({32'(cyc + 1 + RD_LAT), 8'(p)});
    end else begin
      m_gnt = '0;
      m_en  = 1'b0;
      m_we  = 1'b0;
    end
    ev.gnt  = m_gnt;
    ev.en   = m_en;
    ev.we   = m_we;
    ev.addr = m_addr;
    ev.din  = m_din;
    exp_q.push_back(ev);
  endtask

  task automatic check_outputs();
    exp_t            ev;
    logic [39:0]     rq;
    logic [NREQ-1:0] exp_rv;
    if (exp_q.size() == 0) begin
      check_eq("exp_q_underflow", 1, 0);
      ev = '0;
    end else begin
      ev = exp_t'(exp_q.pop_front());
    end
    check_eq("gnt", gnt, ev.gnt);
    check_eq("buf_en", coeff_buf_en, ev.en);
    check_eq("buf_we", coeff_buf_we, ev.we);
    check_eq("buf_addr", coeff_buf_addr, ev.addr);
    check_eq("buf_din", coeff_buf_din, ev.din);
    exp_rv = '0;
    if (rd_q.size() > 0) begin
      rq = rd_q[0];
      if (rq[39:8] == 32'(cyc)) begin
        exp_rv[rq[7:0]] = 1'b1;
        void'(rd_q.pop_front());
      end
    end
    check_eq("rvalid", rvalid, exp_rv);
    if (exp_rv != '0) check_eq("rdata", rdata, t_dout);
  endtask

  // ---------------- driver tasks ----------------
  task automatic new_txn(input int i, input logic w);
    t_we[i]    = w;
    t_addr[i]  = ADDR_W'($urandom_range(0, 511));
    t_wdata[i] = $urandom();
  endtask

  task automatic drive_mode();
    for (int k = 0; k < LINE_W / 32; k++) t_dout[k*32 +: 32] = $urandom();
    for (int i = 0; i < NREQ; i++) begin
      case (mode)
        M_DIRECT: if (m_gnt[i]) t_req[i] = 1'b0;
        M_WR_ALL: begin
          if (m_gnt[i] || !t_req[i]) new_txn(i, 1'b1);
          t_req[i] = 1'b1;
        end
        M_STARVE: begin
          if (i == 0) begin
            if (m_gnt[0]) st_done = 1'b1;
            t_req[0] = !st_done;
            t_we[0]  = 1'b1;
          end else begin
            if (m_gnt[i] || !t_req[i]) new_txn(i, 1'b0);
            t_req[i] = 1'b1;
          end
        end
        default: begin
          if (m_gnt[i]) t_req[i] = 1'b0;
          if (t_req[i]) begin
            if ($urandom_range(0, 19) == 0)     t_req[i] = 1'b0;
            else if ($urandom_range(0, 7) == 0) new_txn(i, 1'($urandom_range(0, 1)));
          end else if ($urandom_range(0, 1) == 1) begin
            t_req[i] = 1'b1;
            new_txn(i, 1'($urandom_range(0, 1)));
          end
        end
      endcase
    end
  endtask

  task automatic load_read(input int i, input logic [ADDR_W-1:0] a);
    t_req[i]  = 1'b1;
    t_we[i]   = 1'b0;
    t_addr[i] = a;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic tick();
    step();
    drive_mode();
    model_step();
  endtask

  task automatic reset_dut();
    #1 rst = 1'b0;
    exp_q.delete();
    rd_q.delete();
    m_gnt = '0; m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_din = '0;
    m_rr = 0; m_cnt = 0;
    t_req = '0;
    #1;
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_en_we", {coeff_buf_en, coeff_buf_we}, 0);
    check_eq("rst_addr", coeff_buf_addr, 0);
    check_eq("rst_din", coeff_buf_din, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    drive_mode();
    model_step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [NREQ-1:0] seqv [4];
    logic [NREQ-1:0] ex;
    int found;
    t_req  = '0;
    t_we   = '0;
    t_dout = '0;
    for (int i = 0; i < NREQ; i++) begin
      t_addr[i]  = '0;
      t_wdata[i] = '0;
    end

    // Single read from port 2 right after reset.
    mode = M_DIRECT;
    reset_dut();
    step(); drive_mode(); load_read(2, 9'h1A5); model_step();
    step();
    check_eq("single_en", coeff_buf_en, 1);
    check_eq("single_we", coeff_buf_we, 0);
    check_eq("single_addr", coeff_buf_addr, 9'h1A5);
    check_eq("single_gnt", gnt, 4'b0100);
    drive_mode(); model_step();
    tick(); tick();
    step();
    check_eq("single_rvalid", rvalid, 4'b0100);
    check_eq("single_rdata", rdata, t_dout);
    drive_mode(); model_step();

    // Back-to-back reads from ports 0, 1, 3 return in issue order.
    seqv = '{4'b0000, 4'b0001, 4'b0010, 4'b1000};
    step(); drive_mode(); load_read(0, 9'h011); model_step();
    step(); drive_mode(); load_read(1, 9'h022); model_step();
    step(); drive_mode(); load_read(3, 9'h033); model_step();
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("read_order", rvalid, seqv[k]);
      drive_mode(); model_step();
    end

    // Reset one cycle after a read issues: the read must never return.
    tick();
    step(); drive_mode(); load_read(1, 9'h0F0); model_step();
    step(); drive_mode(); model_step();
    step();
    reset_dut();
    for (int k = 0; k < RD_LAT + 3; k++) begin
      step();
      check_eq("rst_no_rvalid", rvalid, 0);
      drive_mode(); model_step();
    end

    // All ports writing continuously from rr_ptr=0.
    mode = M_WR_ALL;
    reset_dut();
    for (int k = 1; k <= 8; k++) begin
      step();
      ex = '0;
      ex[(k - 1) % NREQ] = 1'b1;
      check_eq("wr_rr_order", gnt, ex);
      drive_mode(); model_step();
    end

    // Quiesce, then port 0 write against three continuous readers.
    mode = M_DIRECT;
    step(); t_req = '0; drive_mode(); model_step();
    tick(); tick();
    step(); mode = M_STARVE; st_done = 1'b0; drive_mode(); model_step();
    found = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (gnt[0] && found == 0) found = k;
      drive_mode(); model_step();
    end
    check_eq("starve_gnt_bound", (found >= 1 && found <= STARVE_BOUND), 1);

    // Random traffic with withdrawals and in-flight changes.
    mode = M_RANDOM;
    repeat (400) tick();

    mode = M_DIRECT;
    step(); t_req = '0; drive_mode(); model_step();
    repeat (RD_LAT + 3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
